// File: rtl/mul_div_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_div_unit_pkg                                             |
// | Description : Shared opcode / FSM encodings and opcode-decode helpers for  |
// |               the iterative RV32M multiply/divide unit.                    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package mul_div_unit_pkg;

   // Width of the iteration counter (enough for XLEN up to 64)
   localparam int CNT_W = 6;

   // funct3 encodings of the M extension
   localparam logic [2:0] MD_OP_MUL    = 3'd0;
   localparam logic [2:0] MD_OP_MULH   = 3'd1;
   localparam logic [2:0] MD_OP_MULHSU = 3'd2;
   localparam logic [2:0] MD_OP_MULHU  = 3'd3;
   localparam logic [2:0] MD_OP_DIV    = 3'd4;
   localparam logic [2:0] MD_OP_DIVU   = 3'd5;
   localparam logic [2:0] MD_OP_REM    = 3'd6;
   localparam logic [2:0] MD_OP_REMU   = 3'd7;

   // Sequencer states
   localparam logic [1:0] MD_ST_IDLE = 2'd0;
   localparam logic [1:0] MD_ST_CALC = 2'd1;
   localparam logic [1:0] MD_ST_FIX  = 2'd2;
   localparam logic [1:0] MD_ST_DONE = 2'd3;

   // Divide-class opcode (quotient or remainder)
   function automatic logic md_is_div(input logic [2:0] op);
      return op inside {MD_OP_DIV, MD_OP_DIVU, MD_OP_REM, MD_OP_REMU};
   endfunction

   // rs1 is interpreted as two's complement
   function automatic logic md_rs1_signed(input logic [2:0] op);
      return op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_MULHSU, MD_OP_DIV, MD_OP_REM};
   endfunction

   // rs2 is interpreted as two's complement
   function automatic logic md_rs2_signed(input logic [2:0] op);
      return op inside {MD_OP_MUL, MD_OP_MULH, MD_OP_DIV, MD_OP_REM};
   endfunction

   // Multiply variants that return the upper half of the product
   function automatic logic md_returns_high(input logic [2:0] op);
      return op inside {MD_OP_MULH, MD_OP_MULHSU, MD_OP_MULHU};
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_div_unit_div_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_div_unit_div_step                                        |
// | Description : One combinational restoring-divide iteration. Takes the      |
// |               shifted partial remainder (XLEN+1 bits) and the divisor      |
// |               magnitude; returns the next remainder and the quotient bit.  |
// |               Only instantiated when MULDIV_DIV_EN is defined.             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mul_div_unit_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN:0]   i_rem,
   input  logic [XLEN-1:0] i_dvs,
   output logic [XLEN-1:0] o_rem,
   output logic            o_qbit
);

   logic            w_ge;
   logic [XLEN-1:0] w_diff;

   // A set top bit means the shifted remainder already exceeds any divisor.
   // The subtraction result always fits XLEN bits when it is kept.
   assign w_ge   = i_rem[XLEN] | (i_rem[XLEN-1:0] >= i_dvs);
   assign w_diff = i_rem[XLEN-1:0] - i_dvs;
   assign o_qbit = w_ge;
   assign o_rem  = w_ge ? w_diff : i_rem[XLEN-1:0];

endmodule
`default_nettype wire

// File: rtl/mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mul_div_unit                                                 |
// | Description : Iterative RV32M multiply/divide unit for the EX stage.       |
// |               Shift-add multiply and restoring divide, one bit per cycle,  |
// |               on operand magnitudes with a final sign-fix cycle.           |
// |               Optional macro MULDIV_DIV_EN compiles in the divider;        |
// |               without it divide ops complete in one cycle with result 0.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mul_div_unit
   import mul_div_unit_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rst_n_i,
   input  logic            Start_i,
   input  logic            Flush_i,
   input  logic [2:0]      Op_i,
   input  logic [XLEN-1:0] Op1_i,
   input  logic [XLEN-1:0] Op2_i,
   output logic            Busy_o,
   output logic            Done_o,
   output logic [XLEN-1:0] Res_o
);

   localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
   localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]        r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [2:0]        r_op;
   logic [2*XLEN-1:0] r_acc;     // mul: {hi, lo} product; div: {remainder, quotient}
   logic [XLEN-1:0]   r_opb;     // mul: multiplicand magnitude; div: divisor magnitude
   logic              r_neg_q;   // negate product / quotient in FIX
   logic [XLEN-1:0]   r_res;

   logic              w_s1;
   logic              w_s2;
   logic [XLEN-1:0]   w_mag1;
   logic [XLEN-1:0]   w_mag2;
   logic              w_direct;
   logic [XLEN-1:0]   w_direct_res;
   logic [XLEN:0]     w_mul_sum;
   logic [2*XLEN-1:0] w_acc_step;
   logic [2*XLEN-1:0] w_prod_fix;
   logic [XLEN-1:0]   w_fix_res;

`ifdef MULDIV_DIV_EN
   logic              r_neg_r;   // negate remainder in FIX (follows dividend sign)
   logic [XLEN-1:0]   w_rem_next;
   logic              w_qbit;
   logic [XLEN-1:0]   w_quot;
   logic [XLEN-1:0]   w_rem;

   mul_div_unit_div_step #(
      .XLEN   (XLEN)
   ) u_div_step (
      .i_rem  ({r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]}),
      .i_dvs  (r_opb),
      .o_rem  (w_rem_next),
      .o_qbit (w_qbit)
   );

   assign w_quot = r_neg_q ? -r_acc[XLEN-1:0]      : r_acc[XLEN-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];
`endif

   // Operand signs and magnitudes as seen at accept time
   assign w_s1   = md_rs1_signed(Op_i) & Op1_i[XLEN-1];
   assign w_s2   = md_rs2_signed(Op_i) & Op2_i[XLEN-1];
   assign w_mag1 = w_s1 ? -Op1_i : Op1_i;
   assign w_mag2 = w_s2 ? -Op2_i : Op2_i;

   // Ops that bypass the iteration and finish one cycle after accept
   always_comb begin
      w_direct     = 1'b0;
      w_direct_res = '0;
`ifdef MULDIV_DIV_EN
      if (md_is_div(Op_i)) begin
         if (Op2_i == '0) begin
            w_direct     = 1'b1;
            w_direct_res = Op_i[1] ? Op1_i : '1;
         end else if (md_rs1_signed(Op_i) && (Op1_i == INT_MIN) && (Op2_i == '1)) begin
            w_direct     = 1'b1;
            w_direct_res = Op_i[1] ? '0 : INT_MIN;
         end
      end
`else
      if (md_is_div(Op_i)) begin
         w_direct = 1'b1;
      end
`endif
   end

   // One iteration: shift-add multiply, or restoring divide step
   always_comb begin
      w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} + (r_acc[0] ? {1'b0, r_opb} : '0);
      w_acc_step = {w_mul_sum, r_acc[XLEN-1:1]};
`ifdef MULDIV_DIV_EN
      if (md_is_div(r_op)) begin
         w_acc_step = {w_rem_next, r_acc[XLEN-2:0], w_qbit};
      end
`endif
   end

   // Sign correction and result selection used in the FIX cycle
   always_comb begin
      w_prod_fix = r_neg_q ? -r_acc : r_acc;
      w_fix_res  = md_returns_high(r_op) ? w_prod_fix[2*XLEN-1:XLEN] : w_prod_fix[XLEN-1:0];
`ifdef MULDIV_DIV_EN
      if (md_is_div(r_op)) begin
         w_fix_res = r_op[1] ? w_rem : w_quot;
      end
`endif
   end

   // Sequencer and datapath registers
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state <= MD_ST_IDLE;
         r_cnt   <= '0;
         r_op    <= '0;
         r_acc   <= '0;
         r_opb   <= '0;
         r_neg_q <= 1'b0;
         r_res   <= '0;
`ifdef MULDIV_DIV_EN
         r_neg_r <= 1'b0;
`endif
      end else begin
         case (r_state)
            MD_ST_IDLE: begin
               if (Start_i && !Flush_i) begin
                  r_op    <= Op_i;
                  r_neg_q <= w_s1 ^ w_s2;
`ifdef MULDIV_DIV_EN
                  r_neg_r <= w_s1;
`endif
                  if (w_direct) begin
                     r_res   <= w_direct_res;
                     r_state <= MD_ST_DONE;
                  end else begin
                     r_cnt   <= CNT_INIT;
                     r_state <= MD_ST_CALC;
                     if (md_is_div(Op_i)) begin
                        r_acc <= {{XLEN{1'b0}}, w_mag1};
                        r_opb <= w_mag2;
                     end else begin
                        r_acc <= {{XLEN{1'b0}}, w_mag2};
                        r_opb <= w_mag1;
                     end
                  end
               end
            end
            MD_ST_CALC: begin
               if (Flush_i) begin
                  r_state <= MD_ST_IDLE;
               end else begin
                  r_acc <= w_acc_step;
                  if (r_cnt == '0) begin
                     r_state <= MD_ST_FIX;
                  end else begin
                     r_cnt <= r_cnt - CNT_W'(1);
                  end
               end
            end
            MD_ST_FIX: begin
               if (Flush_i) begin
                  r_state <= MD_ST_IDLE;
               end else begin
                  r_res   <= w_fix_res;
                  r_state <= MD_ST_DONE;
               end
            end
            default: begin
               r_state <= MD_ST_IDLE;
            end
         endcase
      end
   end

   assign Busy_o = (r_state != MD_ST_IDLE);
   assign Done_o = (r_state == MD_ST_DONE);
   assign Res_o  = r_res;

endmodule
`default_nettype wire

// File: tb/tb_mul_div_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mul_div_unit                                              |
// | Description : Self-checking bench for mul_div_unit with a plain-arithmetic |
// |               reference model. Honours MULDIV_DIV_EN like the design.      |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_mul_div_unit;

   localparam int XLEN    = 32;
   localparam int LAT_ITR = XLEN + 2;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        Start_i;
   logic        Flush_i;
   logic [2:0]  Op_i;
   logic [31:0] Op1_i;
   logic [31:0] Op2_i;
   logic        Busy_o;
   logic        Done_o;
   logic [31:0] Res_o;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          edge_cnt = 0;
   int          acc_edge = 0;
   logic [31:0] last_res = '0;

   mul_div_unit #(.XLEN(XLEN)) dut (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .Start_i (Start_i),
      .Flush_i (Flush_i),
      .Op_i    (Op_i),
      .Op1_i   (Op1_i),
      .Op2_i   (Op2_i),
      .Busy_o  (Busy_o),
      .Done_o  (Done_o),
      .Res_o   (Res_o)
   );

   // Free-running clock
   always #5 clk_i = ~clk_i;

   // Rising-edge counter used for latency measurement
   always @(posedge clk_i) edge_cnt <= edge_cnt + 1;

   // Reference result from the architectural definition of each op
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      p  = 0;
      case (op)
         3'd0: p = sa * sb;
         3'd1: begin p = sa * sb; p = p >>> 32; end
         3'd2: begin p = sa * ub; p = p >>> 32; end
         3'd3: begin p = ua * ub; p = p >> 32; end
`ifdef MULDIV_DIV_EN
         3'd4: p = (b == 0) ? -1 : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? ua : sa / sb;
         3'd5: p = (b == 0) ? -1 : ua / ub;
         3'd6: p = (b == 0) ? ua : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 0 : sa % sb;
         3'd7: p = (b == 0) ? ua : ua % ub;
`endif
         default: p = 0;
      endcase
      return p[31:0];
   endfunction

   // Reference latency in cycles (accept edge counted as the first)
   function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a,
                                  input logic [31:0] b);
      if (op < 3'd4) return LAT_ITR;
`ifdef MULDIV_DIV_EN
      if (b == 0) return 1;
      if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
      return LAT_ITR;
`else
      return 1;
`endif
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Present a start in IDLE and return #1 after the accepting edge
   task automatic launch(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      @(negedge clk_i);
      Start_i = 1'b1; Op_i = op; Op1_i = a; Op2_i = b;
      @(posedge clk_i); #1;
      acc_edge = edge_cnt;
      Start_i  = 1'b0;
      Op_i     = 3'($urandom_range(0, 7));
      Op1_i    = $urandom;
      Op2_i    = $urandom;
      chk({tag, " busy_after_accept"}, 32'(Busy_o), 32'd1);
   endtask

   // Wait for Done_o, check latency/result and the following idle cycle
   task automatic wait_done(input string tag, input logic [31:0] exp_res, input int exp_lat);
      int guard;
      guard = 0;
      while (Done_o !== 1'b1 && guard < 100) begin
         @(posedge clk_i); #1;
         guard++;
      end
      chk({tag, " latency"}, 32'(edge_cnt - acc_edge + 1), 32'(exp_lat));
      chk({tag, " result"}, Res_o, exp_res);
      chk({tag, " busy_at_done"}, 32'(Busy_o), 32'd1);
      @(posedge clk_i); #1;
      chk({tag, " done_pulse_len"}, 32'(Done_o), 32'd0);
      chk({tag, " busy_after_done"}, 32'(Busy_o), 32'd0);
      chk({tag, " result_held"}, Res_o, exp_res);
      last_res = exp_res;
   endtask

   task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b);
      launch(tag, op, a, b);
      wait_done(tag, ref_res(op, a, b), ref_lat(op, a, b));
   endtask

   initial begin
      logic [2:0]  r_op;
      logic [31:0] a, b;
      int          done_cnt;
      int          guard;

      rst_n_i = 1'b0; Start_i = 1'b0; Flush_i = 1'b0;
      Op_i = '0; Op1_i = '0; Op2_i = '0;

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      chk("reset busy", 32'(Busy_o), 32'd0);
      chk("reset done", 32'(Done_o), 32'd0);
      chk("reset res", Res_o, 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;

      // Flush and Start together in IDLE: no accept
      @(negedge clk_i);
      Start_i = 1'b1; Flush_i = 1'b1; Op_i = 3'd0; Op1_i = 32'd9; Op2_i = 32'd9;
      @(posedge clk_i); #1;
      chk("flush_beats_start busy", 32'(Busy_o), 32'd0);
      Start_i = 1'b0; Flush_i = 1'b0;

      // Directed arithmetic cases
      run_op("mul_7x-3",   3'd0, 32'd7,          32'hFFFF_FFFD);
      run_op("mulh_min",   3'd1, 32'h8000_0000,  32'h8000_0000);
      run_op("mulhu_max",  3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF);
      run_op("mulhsu_-1x2",3'd2, 32'hFFFF_FFFF,  32'd2);
      run_op("div_-7/2",   3'd4, 32'hFFFF_FFF9,  32'd2);
      run_op("rem_-7/2",   3'd6, 32'hFFFF_FFF9,  32'd2);
      run_op("divu_100/7", 3'd5, 32'd100,        32'd7);
      run_op("remu_100/7", 3'd7, 32'd100,        32'd7);
      run_op("div_5/0",    3'd4, 32'd5,          32'd0);
      run_op("rem_5/0",    3'd6, 32'd5,          32'd0);
      run_op("div_ovf",    3'd4, 32'h8000_0000,  32'hFFFF_FFFF);
      run_op("rem_ovf",    3'd6, 32'h8000_0000,  32'hFFFF_FFFF);

      // Start pulsed while busy is ignored
      launch("start_in_calc", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
      repeat (5) @(posedge clk_i);
      @(negedge clk_i);
      Start_i = 1'b1; Op_i = 3'd7; Op1_i = $urandom; Op2_i = $urandom;
      repeat (3) @(negedge clk_i);
      Start_i = 1'b0;
      wait_done("start_in_calc", ref_res(3'd1, 32'h1234_5678, 32'h9ABC_DEF0), LAT_ITR);

      // Flush at cycle 10 of an iterating op
`ifdef MULDIV_DIV_EN
      r_op = 3'd4;
`else
      r_op = 3'd3;
`endif
      launch("flush", r_op, 32'd1000, 32'd7);
      repeat (9) @(posedge clk_i);
      @(negedge clk_i);
      Flush_i = 1'b1;
      @(posedge clk_i); #1;
      Flush_i = 1'b0;
      chk("flush busy", 32'(Busy_o), 32'd0);
      chk("flush done", 32'(Done_o), 32'd0);
      chk("flush res_kept", Res_o, last_res);
      done_cnt = 0;
      repeat (40) begin
         @(posedge clk_i); #1;
         if (Done_o === 1'b1) done_cnt++;
      end
      chk("flush no_done_pulse", 32'(done_cnt), 32'd0);
      chk("flush res_still_kept", Res_o, last_res);

      // Start held through the DONE cycle is taken only once back in IDLE
      launch("b2b_first", 3'd0, 32'd2, 32'd3);
      guard = 0;
      while (Done_o !== 1'b1 && guard < 100) begin
         @(posedge clk_i); #1;
         guard++;
      end
      chk("b2b_first result", Res_o, 32'd6);
      @(negedge clk_i);
      Start_i = 1'b1; Op_i = 3'd0; Op1_i = 32'd5; Op2_i = 32'd6;
      @(posedge clk_i); #1;
      chk("start_in_done ignored", 32'(Busy_o), 32'd0);
      @(posedge clk_i); #1;
      acc_edge = edge_cnt;
      Start_i  = 1'b0;
      chk("b2b_second accepted", 32'(Busy_o), 32'd1);
      wait_done("b2b_second", 32'd30, LAT_ITR);

      // Asynchronous reset in the middle of an iteration
      launch("async_rst", 3'd0, 32'h0000_1234, 32'd5);
      repeat (5) @(posedge clk_i);
      #3;
      rst_n_i = 1'b0;
      #1;
      chk("async_rst busy", 32'(Busy_o), 32'd0);
      chk("async_rst done", 32'(Done_o), 32'd0);
      chk("async_rst res", Res_o, 32'd0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      run_op("mul_3x4", 3'd0, 32'd3, 32'd4);
      run_op("divu_9/3", 3'd5, 32'd9, 32'd3);

      // Randomized operations against the reference model
      for (int i = 0; i < 40; i++) begin
         r_op = 3'($urandom_range(0, 7));
         a    = $urandom;
         b    = $urandom;
         case ($urandom_range(0, 9))
            0: b = 32'd0;
            1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            2: begin a = 32'($urandom_range(0, 255)); b = 32'($urandom_range(1, 15)); end
            3: b = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            default: ;
         endcase
         run_op($sformatf("rand%0d_op%0d", i, r_op), r_op, a, b);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
